mux4_sel: RTL and testbench
===========================

Name: mux4_sel

Overview:
- 4-to-1 word multiplexer for datapath operand selection.
- A 2-bit selector picks one of four WIDTH-bit inputs a, b, c, d.
- The selected word is driven combinationally on out, so the same-cycle path has zero latency.
- A registered copy (out_q, sel_q, valid_q) is also provided for timing-critical consumers; it sits on the single system clock with a synchronous active-high reset.

Parameters:
- WIDTH, 16, bit width of each data input and of both data outputs.
- RESET_VAL, 0, value loaded into out_q on reset (WIDTH bits).

Ports:
- clk  input  1  system clock; all registers update on its rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  data input selected when selector = 2'b00.
- b  input  WIDTH  data input selected when selector = 2'b01.
- c  input  WIDTH  data input selected when selector = 2'b10.
- d  input  WIDTH  data input selected when selector = 2'b11.
- selector  input  2  input select code.
- en  input  1  register-stage capture enable; tie high if unused.
- out  output  WIDTH  combinational selected word.
- out_q  output  WIDTH  registered selected word.
- sel_q  output  2  selector value captured alongside out_q.
- valid_q  output  1  high once out_q holds a captured value since the last reset.

Behaviour:
- Combinational path, purely combinational with no dependency on clk or rst:
  - out = a when selector = 00, b when 01, c when 10, d when 11.
  - out reflects input or selector changes within the same delta/cycle; zero latency.
- X/Z handling: if selector contains X/Z, out is X in simulation. Synthesis must use a full case with no latch inferred. The 11 encoding is the default arm.
- Register stage, rising edge of clk:
  - rst = 1: out_q <= RESET_VAL, sel_q <= 2'b00, valid_q <= 0. Reset has priority over en.
  - rst = 0, en = 1: out_q <= mux result for the current selector and inputs; sel_q <= selector; valid_q <= 1.
  - rst = 0, en = 0: out_q, sel_q and valid_q hold their values.
- Latency: out_q and sel_q lag out and selector by exactly one clock when en = 1.
- Reset mid-operation: on the edge where rst is sampled high, all registered outputs return to reset values. out keeps following the inputs during reset.
- Simultaneous selector and data change: the register captures the combination present at the sampling edge. No glitch filtering is required.
- Width rule: no truncation or extension; every data path is exactly WIDTH bits.
- No internal state beyond out_q, sel_q and valid_q.

Test Plan:
1. Inputs a=16'h0001, b=16'h0003, c=16'h0000, d=16'h0002:
   - selector=01 -> out=16'h0003 immediately.
   - Next rising edge with en=1, rst=0 -> out_q=16'h0003, sel_q=01, valid_q=1.
2. Same data, selector changed to 11 -> out=16'h0002 the same cycle; out_q=16'h0002 one edge later.
3. Sweep selector 00, 01, 10, 11 with a=16'hAAAA, b=16'h5555, c=16'hFFFF, d=16'h1234:
   - out = AAAA, 5555, FFFF, 1234 respectively.
   - out_q tracks each value delayed one clock.
4. rst=1 for one edge while selector=01 and b=16'h0003:
   - out_q=RESET_VAL (0), sel_q=00, valid_q=0 after that edge.
   - out stays 16'h0003.
   - After rst is deasserted, out_q=16'h0003 on the next edge with en=1.
5. en=0 with selector changed 01->10 -> out=c immediately; out_q, sel_q and valid_q hold their prior values across several edges.
6. rst=1 and en=1 on the same edge -> reset values win: out_q=0, valid_q=0.

Source files
------------

// File: rtl/mux4_sel.sv
// 4-to-1 operand multiplexer: zero-latency combinational output plus a
// registered copy (word, select code, valid) for timing-critical consumers.
module mux4_sel #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       selector,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [1:0]       sel_q,
  output logic             valid_q
);

  logic [WIDTH-1:0] data_arr [4];
  logic [WIDTH-1:0] mux_word;

  logic [WIDTH-1:0] out_q_reg, out_q_next;
  logic [1:0]       sel_q_reg, sel_q_next;
  logic             valid_q_reg, valid_q_next;

  // Operand table indexed by select code: a=00, b=01, c=10, d=11.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_operand
      if (gi == 0) begin : g_a
        assign data_arr[gi] = a;
      end else if (gi == 1) begin : g_b
        assign data_arr[gi] = b;
      end else if (gi == 2) begin : g_c
        assign data_arr[gi] = c;
      end else begin : g_d
        assign data_arr[gi] = d;
      end
    end
  endgenerate

  // The default arm covers 11; an unknown selector yields X in simulation
  // while synthesis treats that X as don't-care and folds it onto d.
  always_comb begin
    mux_word = '0;
    case (selector)
      2'b00:   mux_word = data_arr[0];
      2'b01:   mux_word = data_arr[1];
      2'b10:   mux_word = data_arr[2];
      default: mux_word = (selector == 2'b11) ? data_arr[3] : {WIDTH{1'bx}};
    endcase
  end

  assign out = mux_word;

  always_comb begin
    out_q_next   = out_q_reg;
    sel_q_next   = sel_q_reg;
    valid_q_next = valid_q_reg;
    if (en) begin
      out_q_next   = mux_word;
      sel_q_next   = selector;
      valid_q_next = 1'b1;
    end
  end

  // Reset takes priority over the capture enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q_reg   <= RESET_VAL;
      sel_q_reg   <= 2'b00;
      valid_q_reg <= 1'b0;
    end else begin
      out_q_reg   <= out_q_next;
      sel_q_reg   <= sel_q_next;
      valid_q_reg <= valid_q_next;
    end
  end

  assign out_q   = out_q_reg;
  assign sel_q   = sel_q_reg;
  assign valid_q = valid_q_reg;

endmodule

// File: tb/tb_mux4_sel.sv
// Directed bench for mux4_sel: combinational output checked in-cycle, the
// registered stage checked one edge later through an expected-value queue.
module tb_mux4_sel;

  localparam int unsigned      W  = 16;
  localparam logic [W-1:0]     RV = '0;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] a, b, c, d;
  logic [1:0]   selector;
  logic [W-1:0] out, out_q;
  logic [1:0]   sel_q;
  logic         valid_q;

  typedef struct packed {
    logic [W-1:0] o;
    logic [1:0]   s;
    logic         v;
  } reg_t;

  reg_t sb[$];
  reg_t model;
  int   checks   = 0;
  int   failures = 0;

  mux4_sel #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .selector (selector),
    .en       (en),
    .out      (out),
    .out_q    (out_q),
    .sel_q    (sel_q),
    .valid_q  (valid_q)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pick(input logic [1:0] s);
    logic [W-1:0] w [4];
    w[0] = a;
    w[1] = b;
    w[2] = c;
    w[3] = d;
    return w[s];
  endfunction

  task automatic step(input string tag, input logic [1:0] s, input logic e, input logic r);
    reg_t         exp;
    logic [W-1:0] exp_out;
    @(negedge clk);
    selector = s;
    en       = e;
    rst      = r;
    #1;
    exp_out = pick(s);
    checks++;
    assert (out === exp_out) else begin
      failures++;
      $error("FAIL %s out got=%h exp=%h", tag, out, exp_out);
    end
    if (r)
      model = '{o: RV, s: 2'b00, v: 1'b0};
    else if (e)
      model = '{o: exp_out, s: s, v: 1'b1};
    sb.push_back(model);
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    checks++;
    assert (out_q === exp.o) else begin
      failures++;
      $error("FAIL %s out_q got=%h exp=%h", tag, out_q, exp.o);
    end
    checks++;
    assert (sel_q === exp.s) else begin
      failures++;
      $error("FAIL %s sel_q got=%b exp=%b", tag, sel_q, exp.s);
    end
    checks++;
    assert (valid_q === exp.v) else begin
      failures++;
      $error("FAIL %s valid_q got=%b exp=%b", tag, valid_q, exp.v);
    end
    $display("%-10s sel=%b en=%b rst=%b out=%h out_q=%h sel_q=%b valid_q=%b",
             tag, s, e, r, out, out_q, sel_q, valid_q);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    selector = 2'b00;
    a = 16'h0001; b = 16'h0003; c = 16'h0000; d = 16'h0002;
    model = '{o: RV, s: 2'b00, v: 1'b0};

    step("reset", 2'b00, 1'b0, 1'b1);

    step("t1_sel01", 2'b01, 1'b1, 1'b0);
    step("t2_sel11", 2'b11, 1'b1, 1'b0);

    a = 16'hAAAA; b = 16'h5555; c = 16'hFFFF; d = 16'h1234;
    step("t3_sel00", 2'b00, 1'b1, 1'b0);
    step("t3_sel01", 2'b01, 1'b1, 1'b0);
    step("t3_sel10", 2'b10, 1'b1, 1'b0);
    step("t3_sel11", 2'b11, 1'b1, 1'b0);

    b = 16'h0003;
    step("t4_pre", 2'b01, 1'b1, 1'b0);
    step("t4_rst", 2'b01, 1'b1, 1'b1);
    step("t4_post", 2'b01, 1'b1, 1'b0);

    step("t5_hold0", 2'b10, 1'b0, 1'b0);
    step("t5_hold1", 2'b10, 1'b0, 1'b0);
    c = 16'h0F0F;
    step("t5_hold2", 2'b00, 1'b0, 1'b0);

    step("t6_pre", 2'b11, 1'b1, 1'b0);
    step("t6_rst_en", 2'b01, 1'b1, 1'b1);

    // Data and selector changing together: the sampling edge sees the new pair.
    a = 16'h1357; d = 16'hBEEF;
    step("t7_simul", 2'b11, 1'b1, 1'b0);
    step("t7_simul2", 2'b00, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
